// File: rtl/enc4_arb.sv
// Registered 4-to-2 request encoder with round-robin arbitration and valid/ACK handshake.
// Optional sticky overflow flag OVF is built in when ENC4_OVF_EN is defined.
module enc4_arb (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic ACK,
  output logic I0,
  output logic I1,
  output logic V
`ifdef ENC4_OVF_EN
  ,
  output logic OVF
`endif
);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_VALID = 1'b1;

  logic       r_state;
  logic [3:0] r_p;
  logic [1:0] r_last;
  logic [1:0] r_code;

  logic [3:0] w_req;
  logic [3:0] w_clr;
  logic       w_accept;
  logic [1:0] w_pick;

  // First pending index after the last grant, wrapping through all four lines.
  function automatic logic [1:0] rr_pick(input logic [3:0] p, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && p[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign w_accept = (r_state == S_VALID) && ACK;
  assign w_clr    = w_accept ? (4'b0001 << r_code) : 4'b0000;
  assign w_req    = EN ? {D3, D2, D1, D0} : 4'b0000;
  assign w_pick   = rr_pick(r_p, r_last);

  // Set-wins capture: new requests are OR-ed in after the grant clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_p     <= 4'b0000;
      r_last  <= 2'b11;
      r_state <= S_IDLE;
      r_code  <= 2'b00;
    end else begin
      r_p <= (r_p & ~w_clr) | w_req;
      case (r_state)
        S_IDLE: begin
          if (|r_p) begin
            r_code  <= w_pick;
            r_state <= S_VALID;
          end
        end
        default: begin
          if (ACK) begin
            r_last  <= r_code;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign V  = (r_state == S_VALID);
  assign I0 = r_code[0];
  assign I1 = r_code[1];

`ifdef ENC4_OVF_EN
  logic       r_ovf;
  logic [3:0] w_merge;

  // A request landing on a bit that is still pending and not being cleared is lost.
  assign w_merge = w_req & r_p & ~w_clr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_ovf <= 1'b0;
    else     r_ovf <= r_ovf | (|w_merge);
  end

  assign OVF = r_ovf;
`endif

endmodule

// File: tb/tb_enc4_arb.sv
// Bench for enc4_arb: directed scenarios plus randomized traffic against a pending-list model.
// Define ENC4_OVF_EN for both files to also exercise the overflow flag.
module tb_enc4_arb;

  logic CLK = 1'b0;
  logic RST, EN, D0, D1, D2, D3, ACK;
  logic I0, I1, V;
`ifdef ENC4_OVF_EN
  logic OVF;
`endif

  int total = 0;
  int bad   = 0;

  // Behavioural model: pending flags, last grant, current grant.
  bit m_p[4];
  int m_last;
  bit m_v;
  int m_code;
  bit m_ovf;

  enc4_arb dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .ACK(ACK), .I0(I0), .I1(I1), .V(V)
`ifdef ENC4_OVF_EN
    , .OVF(OVF)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) m_p[k] = 1'b0;
    m_last = 3;
    m_v    = 1'b0;
    m_code = 0;
    m_ovf  = 1'b0;
  endfunction

  function automatic void model_edge(input bit en, input bit [3:0] d, input bit ack);
    int clr;
    bit done;
    clr  = (m_v && ack) ? m_code : -1;
    done = 1'b0;
    if (!m_v) begin
      for (int i = 1; i <= 4; i++) begin
        if (!done && m_p[(m_last + i) % 4]) begin
          m_code = (m_last + i) % 4;
          m_v    = 1'b1;
          done   = 1'b1;
        end
      end
    end else if (ack) begin
      m_last = m_code;
      m_v    = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      if (en && d[k] && m_p[k] && k != clr) m_ovf = 1'b1;
      m_p[k] = (m_p[k] && k != clr) || (en && d[k]);
    end
  endfunction

  task automatic step(input bit en, input bit [3:0] d, input bit ack);
    EN = en; {D3, D2, D1, D0} = d; ACK = ack;
    @(posedge CLK);
    model_edge(en, d, ack);
    #1;
  endtask

  task automatic do_reset();
    EN = 1'b0; {D3, D2, D1, D0} = 4'b0000; ACK = 1'b0;
    RST = 1'b1;
    #3;
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    EN = 1'b0; {D3, D2, D1, D0} = 4'b0000; ACK = 1'b0;
    RST = 1'b1;
    #1;
    total++;
    if ({V, I1, I0} !== 3'b000) begin
      bad++; $display("FAIL reset_init: got V,I=%b want 000", {V, I1, I0});
    end
`ifdef ENC4_OVF_EN
    total++;
    if (OVF !== 1'b0) begin
      bad++; $display("FAIL reset_ovf: got %b want 0", OVF);
    end
`endif
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
    step(1, 4'b0100, 0);
    step(1, 4'b0000, 0);
    total++;
    if ({V, I1, I0} !== 3'b110) begin
      bad++; $display("FAIL reset_pre_valid: got V,I=%b want 110", {V, I1, I0});
    end
    #2 RST = 1'b1;
    #1;
    total++;
    if ({V, I1, I0} !== 3'b000) begin
      bad++; $display("FAIL reset_async: got V,I=%b want 000", {V, I1, I0});
    end
    RST = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 4'b0000, 0);
      total++;
      if (V !== 1'b0) begin
        bad++; $display("FAIL reset_idle: cycle %0d got V=%b want 0", i, V);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    step(1, 4'b0100, 0);
    total++;
    if (V !== 1'b0) begin
      bad++; $display("FAIL single_edge_n: got V=%b want 0", V);
    end
    step(1, 4'b0000, 0);
    total++;
    if ({V, I1, I0} !== 3'b110) begin
      bad++; $display("FAIL single_grant: got V,I=%b want 110", {V, I1, I0});
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 4'b0000, 0);
      total++;
      if ({V, I1, I0} !== 3'b110) begin
        bad++; $display("FAIL single_hold: cycle %0d got V,I=%b want 110", i, {V, I1, I0});
      end
    end
    step(1, 4'b0000, 1);
    total++;
    if (V !== 1'b0 || {I1, I0} !== 2'b10) begin
      bad++; $display("FAIL single_ack: got V,I=%b want 010", {V, I1, I0});
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 4'b0000, i[0]);
      total++;
      if (V !== 1'b0) begin
        bad++; $display("FAIL single_after: cycle %0d got V=%b want 0", i, V);
      end
    end
  endtask

  task automatic test_round_robin();
    int got[$];
    int exp_codes[4] = '{0, 1, 2, 3};
    do_reset();
    step(1, 4'b1111, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 4'b0000, 1);
      total++;
      if (V !== (i % 2 == 0)) begin
        bad++; $display("FAIL rr_spacing: cycle %0d got V=%b want %0b", i, V, (i % 2 == 0));
      end
      if (V === 1'b1) got.push_back(int'({I1, I0}));
    end
    total++;
    if (got.size() != 4) begin
      bad++; $display("FAIL rr_count: got %0d grants want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got[i] != exp_codes[i]) begin
          bad++; $display("FAIL rr_order: grant %0d got %0d want %0d", i, got[i], exp_codes[i]);
        end
      end
    end
  endtask

  task automatic test_rotation();
    do_reset();
    step(1, 4'b0100, 0);
    step(1, 4'b0000, 0);
    step(1, 4'b0000, 1);
    step(1, 4'b1001, 0);
    step(1, 4'b0000, 0);
    total++;
    if ({V, I1, I0} !== 3'b111) begin
      bad++; $display("FAIL rot_first: got V,I=%b want 111", {V, I1, I0});
    end
    step(1, 4'b0000, 1);
    step(1, 4'b0000, 0);
    total++;
    if ({V, I1, I0} !== 3'b100) begin
      bad++; $display("FAIL rot_second: got V,I=%b want 100", {V, I1, I0});
    end
    do_reset();
    step(1, 4'b0010, 0);
    step(1, 4'b0000, 0);
    step(1, 4'b0010, 1);
    total++;
    if (V !== 1'b0) begin
      bad++; $display("FAIL setwins_ack: got V=%b want 0", V);
    end
    step(1, 4'b0000, 0);
    total++;
    if ({V, I1, I0} !== 3'b101) begin
      bad++; $display("FAIL setwins_regrant: got V,I=%b want 101", {V, I1, I0});
    end
  endtask

  task automatic test_enable();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, (i < 3) ? 4'b0010 : 4'b0000, 0);
      total++;
      if (V !== 1'b0) begin
        bad++; $display("FAIL en_block: cycle %0d got V=%b want 0", i, V);
      end
    end
    step(1, 4'b0001, 0);
    step(0, 4'b0010, 0);
    total++;
    if ({V, I1, I0} !== 3'b100) begin
      bad++; $display("FAIL en_pending: got V,I=%b want 100", {V, I1, I0});
    end
    step(0, 4'b0000, 1);
    step(0, 4'b0000, 0);
    total++;
    if (V !== 1'b0) begin
      bad++; $display("FAIL en_drained: got V=%b want 0", V);
    end
  endtask

`ifdef ENC4_OVF_EN
  task automatic test_ovf();
    do_reset();
    step(1, 4'b1000, 0);
    step(1, 4'b0000, 0);
    step(1, 4'b0000, 0);
    total++;
    if (OVF !== 1'b0) begin
      bad++; $display("FAIL ovf_early: got %b want 0", OVF);
    end
    step(1, 4'b1000, 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (OVF !== 1'b1) begin
        bad++; $display("FAIL ovf_sticky: cycle %0d got %b want 1", i, OVF);
      end
      step(1, 4'b0000, 1);
    end
    do_reset();
    step(1, 4'b1000, 0);
    step(1, 4'b0000, 0);
    step(1, 4'b1000, 1);
    step(1, 4'b0000, 0);
    total++;
    if (OVF !== 1'b0) begin
      bad++; $display("FAIL ovf_on_ack: got %b want 0", OVF);
    end
  endtask
`endif

  task automatic test_random();
    bit en, ack;
    bit [3:0] d;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      d   = 4'($urandom) & 4'($urandom);
      ack = 1'($urandom_range(0, 1));
      step(en, d, ack);
      total++;
      if (V !== m_v || (m_v && {I1, I0} !== 2'(m_code))) begin
        bad++; $display("FAIL rand: cycle %0d got V,I=%b%b%b want %0b%02b", i, V, I1, I0, m_v, 2'(m_code));
      end
`ifdef ENC4_OVF_EN
      total++;
      if (OVF !== m_ovf) begin
        bad++; $display("FAIL rand_ovf: cycle %0d got %b want %0b", i, OVF, m_ovf);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_rotation();
    test_enable();
`ifdef ENC4_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
